// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - EX-stage handshake bundle between the pipeline and the multiply/divide unit
interface mdu_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] Result;

  modport master (
    output start, Funct3, SrcA, SrcB, flush,
    input  busy, stall, done, Result
  );

  modport slave (
    input  start, Funct3, SrcA, SrcB, flush,
    output busy, stall, done, Result
  );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV32M multiply/divide unit, one bit per cycle
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mdu_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op;
  logic             sign_a, sign_b, special;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  // rem[WIDTH:1] is the partial remainder / product; rem[0] is the next dividend bit
  logic [WIDTH:0]   rem;

  logic             in_div, in_signed, in_sign_a, in_sign_b, in_special;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo, rmd, final_val;

  always_comb begin
    in_div     = bus.Funct3[2];
    in_signed  = in_div & ~bus.Funct3[0];
    in_sign_a  = in_signed & bus.SrcA[WIDTH-1];
    in_sign_b  = in_signed & bus.SrcB[WIDTH-1];
    mag_a      = in_sign_a ? -bus.SrcA : bus.SrcA;
    mag_b      = in_sign_b ? -bus.SrcB : bus.SrcB;
    in_special = in_div && ((bus.SrcB == '0) ||
                 (in_signed && bus.SrcA == MIN_INT && bus.SrcB == '1));
  end

  always_comb begin
    trial = rem - {1'b0, b_reg};
    if (special) begin
      quo = (b_reg == '0) ? '1 : MIN_INT;
      rmd = (b_reg == '0) ? a_reg : '0;
    end else begin
      quo = (sign_a ^ sign_b) ? -a_reg : a_reg;
      rmd = sign_a ? -rem[WIDTH:1] : rem[WIDTH:1];
    end
    if (!op[2])
      final_val = rem[WIDTH:1];
    else if (op[1])
      final_val = rmd;
    else
      final_val = quo;
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.stall  = bus.start && !bus.done;
  assign bus.Result = (state == DONE) ? final_val : result_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      special    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem        <= '0;
      result_reg <= '0;
    end else begin
      // a flush in DONE still retires the result that done already announced
      if (state == DONE)
        result_reg <= final_val;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (bus.start) begin
            op      <= bus.Funct3;
            sign_a  <= in_sign_a;
            sign_b  <= in_sign_b;
            special <= in_special;
            cnt     <= '0;
            if (!in_div) begin
              a_reg <= bus.SrcA;
              b_reg <= bus.SrcB;
              rem   <= '0;
            end else begin
              a_reg <= in_special ? bus.SrcA : mag_a;
              b_reg <= mag_b;
              rem   <= {{WIDTH{1'b0}}, mag_a[WIDTH-1]};
            end
            state <= in_special ? DONE : CALC;
          end
          CALC: begin
            cnt <= cnt + 1'b1;
            if (op[2]) begin
              rem   <= trial[WIDTH] ? {rem[WIDTH-1:0], a_reg[WIDTH-2]}
                                    : {trial[WIDTH-1:0], a_reg[WIDTH-2]};
              a_reg <= {a_reg[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
              if (b_reg[0])
                rem <= {rem[WIDTH:1] + a_reg, 1'b0};
              a_reg <= a_reg << 1;
              b_reg <= b_reg >> 1;
            end
            if (cnt == CW'(WIDTH - 1))
              state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
